// File: rtl/note_playback_reader_pkg.sv
// Shared definitions for the note playback reader: state encoding and the
// recorded-entry field layout (press flag, key, delta; MSB first), which the
// recorder must agree with.
package note_playback_reader_pkg;

    localparam int unsigned DEF_ADDR_W   = 8;
    localparam int unsigned DEF_KEY_W    = 5;
    localparam int unsigned DEF_NUM_KEYS = 32;
    localparam int unsigned DEF_DELTA_W  = 16;

    typedef enum logic [2:0] {
        PB_IDLE  = 3'd0,
        PB_FETCH = 3'd1,
        PB_LATCH = 3'd2,
        PB_WAIT  = 3'd3,
        PB_EMIT  = 3'd4,
        PB_DONE  = 3'd5
    } pb_state_e;

    // Delta occupies the low bits, key sits directly above it
    function automatic int unsigned entry_key_lsb(input int unsigned delta_w);
        return delta_w;
    endfunction

    // Press flag is the entry MSB
    function automatic int unsigned entry_press_pos(input int unsigned key_w,
                                                    input int unsigned delta_w);
        return key_w + delta_w;
    endfunction

    function automatic int unsigned entry_width(input int unsigned key_w,
                                                input int unsigned delta_w);
        return 1 + key_w + delta_w;
    endfunction

endpackage

// File: rtl/playback_delta_timer.sv
// Counts timebase ticks up to the current entry's delta; saturates there.
module playback_delta_timer #(
    parameter int unsigned DELTA_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               tick,
    input  logic [DELTA_W-1:0] delta,
    output logic               expired
);

    logic [DELTA_W-1:0] cnt_q;

    // Clear on load, otherwise count ticks until the delta is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (tick && (cnt_q != delta)) begin
            cnt_q <= cnt_q + DELTA_W'(1);
        end
    end

    assign expired = (cnt_q == delta);

endmodule

// File: rtl/note_playback_reader.sv
// Replays recorded key events from the recording RAM, waiting each entry's
// delta in timebase ticks, and drives a held-note bitmap plus event strobe.
module note_playback_reader
    import note_playback_reader_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned KEY_W    = DEF_KEY_W,
    parameter int unsigned NUM_KEYS = DEF_NUM_KEYS,
    parameter int unsigned DELTA_W  = DEF_DELTA_W
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        loopEnable,
    input  logic                        tick,
    input  logic [ADDR_W:0]             entryCount,
    output logic [ADDR_W-1:0]           memAddr,
    input  logic [KEY_W+DELTA_W:0]      memReadData,
    output logic [NUM_KEYS-1:0]         noteActive,
    output logic                        eventValid,
    output logic [KEY_W-1:0]            eventKey,
    output logic                        eventPress,
    output logic                        playing,
    output logic                        done
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned ENTRY_W   = entry_width(KEY_W, DELTA_W);
    localparam int unsigned KEY_LSB   = entry_key_lsb(DELTA_W);
    localparam int unsigned PRESS_POS = entry_press_pos(KEY_W, DELTA_W);

    pb_state_e            state_q, state_d;
    logic [ADDR_W-1:0]    index_q, index_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ENTRY_W-1:0]   entry_q, entry_d;
    logic [NUM_KEYS-1:0]  notes_q, notes_d;
    logic                 ev_valid_q, ev_valid_d;
    logic [KEY_W-1:0]     ev_key_q, ev_key_d;
    logic                 ev_press_q, ev_press_d;
    logic                 playing_q, playing_d;
    logic                 done_q, done_d;

    logic                 timer_load;
    logic                 timer_tick;
    logic                 timer_expired;
    logic [KEY_W-1:0]     entry_key;
    logic                 entry_press;
    logic [DELTA_W-1:0]   entry_delta;

    assign entry_key   = entry_q[KEY_LSB +: KEY_W];
    assign entry_press = entry_q[PRESS_POS];
    assign entry_delta = entry_q[DELTA_W-1:0];

    // Ticks only advance the delay while waiting on an entry
    assign timer_tick = tick && (state_q == PB_WAIT);

    playback_delta_timer #(
        .DELTA_W (DELTA_W)
    ) u_delta_timer (
        .clk     (CLOCK_50),
        .rst     (reset),
        .load    (timer_load),
        .tick    (timer_tick),
        .delta   (entry_delta),
        .expired (timer_expired)
    );

    // State and registered outputs
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= PB_IDLE;
            index_q    <= '0;
            count_q    <= '0;
            entry_q    <= '0;
            notes_q    <= '0;
            ev_valid_q <= 1'b0;
            ev_key_q   <= '0;
            ev_press_q <= 1'b0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            count_q    <= count_d;
            entry_q    <= entry_d;
            notes_q    <= notes_d;
            ev_valid_q <= ev_valid_d;
            ev_key_q   <= ev_key_d;
            ev_press_q <= ev_press_d;
            playing_q  <= playing_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output logic; stop overrides everything
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        count_d    = count_q;
        entry_d    = entry_q;
        notes_d    = notes_q;
        ev_valid_d = 1'b0;
        ev_key_d   = ev_key_q;
        ev_press_d = ev_press_q;
        done_d     = 1'b0;
        timer_load = 1'b0;

        case (state_q)
            PB_IDLE: begin
                if (start) begin
                    count_d = entryCount;
                    index_d = '0;
                    state_d = (entryCount == '0) ? PB_DONE : PB_FETCH;
                end
            end
            PB_FETCH: begin
                state_d = PB_LATCH;
            end
            PB_LATCH: begin
                entry_d    = memReadData;
                timer_load = 1'b1;
                state_d    = PB_WAIT;
            end
            PB_WAIT: begin
                if (timer_expired) begin
                    ev_valid_d         = 1'b1;
                    ev_key_d           = entry_key;
                    ev_press_d         = entry_press;
                    notes_d[entry_key] = entry_press;
                    state_d            = PB_EMIT;
                end
            end
            PB_EMIT: begin
                if ((CNT_W'(index_q) + CNT_W'(1)) < count_q) begin
                    index_d = index_q + ADDR_W'(1);
                    state_d = PB_FETCH;
                end else if (loopEnable) begin
                    index_d = '0;
                    notes_d = '0;
                    state_d = PB_FETCH;
                end else begin
                    state_d = PB_DONE;
                end
            end
            PB_DONE: begin
                done_d  = 1'b1;
                notes_d = '0;
                state_d = PB_IDLE;
            end
            default: begin
                state_d = PB_IDLE;
            end
        endcase

        if (stop) begin
            state_d    = PB_IDLE;
            notes_d    = '0;
            ev_valid_d = 1'b0;
            done_d     = 1'b0;
        end

        playing_d = (state_d != PB_IDLE) && (state_d != PB_DONE);
    end

    assign memAddr    = index_q;
    assign noteActive = notes_q;
    assign eventValid = ev_valid_q;
    assign eventKey   = ev_key_q;
    assign eventPress = ev_press_q;
    assign playing    = playing_q;
    assign done       = done_q;

endmodule
